noc_link_checker: RTL and testbench

Passive per-link NoC protocol checker and statistics collector for the OpTiMSoC simulation environment. It observes one NoC link (all virtual channels) at the compute-tile/router boundary, where the system testbench taps `link_in_*`/`link_out_*`. It tracks packet framing per virtual channel, checks the valid/ready handshake rules, counts packets and stall cycles, and raises sticky error flags. It never drives the link, so it can be instantiated once per link direction beside the NoC tracer.

---
 rtl/noc_link_checker.sv | 164 ++++++++++++++++
 tb/tb_noc_link_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_checker.sv
// noc_link_checker: passive per-link NoC protocol checker and statistics
// collector. Observes every virtual channel of one link, tracks packet
// framing, checks the valid/ready handshake rules, counts packets and stall
// cycles, and keeps sticky error flags. It never drives the link.
//
// Build option: define OPTIMSOC_NOC_CHECKER_STALLCNT_EN to build the per-VC
// stall counters. Without it no stall-counter registers are built and
// stall_count reads 0.
//
// Error flag layout per VC: {dest, length, data_change, valid_drop}.
module noc_link_checker #(
  parameter int FLIT_WIDTH  = 32,
  parameter int CHANNELS    = 2,
  parameter int MAX_PKT_LEN = 8,
  parameter int NUM_DEST    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] flit,
  input  logic [CHANNELS-1:0]            last,
  input  logic [CHANNELS-1:0]            valid,
  input  logic [CHANNELS-1:0]            ready,
  output logic [CHANNELS*16-1:0]         pkt_count,
  output logic [CHANNELS*16-1:0]         stall_count,
  output logic [CHANNELS*4-1:0]          err,
  output logic                           err_any
);

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // Parameters widened once so the comparisons below stay width-matched.
  localparam logic [31:0] NUM_DEST_L    = 32'(NUM_DEST);
  localparam logic [31:0] MAX_PKT_LEN_L = 32'(MAX_PKT_LEN);

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    logic [FLIT_WIDTH-1:0] flit_s;
    logic                  hs_s;
    logic                  header_s;
    logic                  done_s;
    logic [4:0]            dest_s;
    logic [3:0]            len_next_s;
    logic                  dest_err_s;
    logic                  len_err_s;
    logic                  drop_err_s;
    logic                  chg_err_s;
    logic [3:0]            new_err_s;

    state_t                state_r;
    logic [3:0]            len_r;
    logic [15:0]           pkt_r;
    logic [3:0]            err_r;
    logic                  prev_valid_r;
    logic                  prev_ready_r;
    logic                  prev_last_r;
    logic [FLIT_WIDTH-1:0] prev_flit_r;

    assign flit_s = flit[v*FLIT_WIDTH +: FLIT_WIDTH];

    // Decode this cycle's handshake, framing and protocol-violation events.
    always_comb begin
      hs_s     = valid[v] & ready[v];
      header_s = hs_s & (state_r == IDLE);
      done_s   = hs_s & last[v];
      dest_s   = flit_s[FLIT_WIDTH-1 -: 5];
      // Length the packet will have once this flit is accepted (saturating).
      if (state_r == IDLE) begin
        len_next_s = 4'd1;
      end else if (len_r == 4'd15) begin
        len_next_s = 4'd15;
      end else begin
        len_next_s = len_r + 4'd1;
      end
      dest_err_s = header_s & ({27'd0, dest_s} >= NUM_DEST_L);
      len_err_s  = hs_s & ({28'd0, len_next_s} > MAX_PKT_LEN_L);
      // A stalled flit must stay valid and unchanged until it is accepted.
      drop_err_s = prev_valid_r & ~prev_ready_r & ~valid[v];
      chg_err_s  = prev_valid_r & ~prev_ready_r & valid[v] &
                   ((flit_s != prev_flit_r) | (last[v] != prev_last_r));
      new_err_s  = {dest_err_s, len_err_s, chg_err_s, drop_err_s};
    end

    // Framing FSM with its length counter; reset drops any partial packet.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
        len_r   <= 4'd0;
      end else if (hs_s) begin
        len_r <= len_next_s;
        case (state_r)
          IDLE:    state_r <= last[v] ? IDLE : PAYLOAD;
          PAYLOAD: state_r <= last[v] ? IDLE : PAYLOAD;
          default: state_r <= IDLE;
        endcase
      end else begin
        state_r <= state_r;
        len_r   <= len_r;
      end
    end

    // Packet counter and sticky errors; a new event on a clear cycle still lands.
    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_r <= 16'd0;
        err_r <= 4'd0;
      end else if (clear) begin
        pkt_r <= done_s ? 16'd1 : 16'd0;
        err_r <= new_err_s;
      end else begin
        pkt_r <= pkt_r + (done_s ? 16'd1 : 16'd0);
        err_r <= err_r | new_err_s;
      end
    end

    // History of the previous cycle; only rst clears it so clear never
    // fabricates or hides a handshake violation.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_valid_r <= 1'b0;
        prev_ready_r <= 1'b0;
        prev_last_r  <= 1'b0;
        prev_flit_r  <= '0;
      end else begin
        prev_valid_r <= valid[v];
        prev_ready_r <= ready[v];
        prev_last_r  <= last[v];
        prev_flit_r  <= flit_s;
      end
    end

`ifdef OPTIMSOC_NOC_CHECKER_STALLCNT_EN
    logic        stall_s;
    logic [15:0] stall_r;

    assign stall_s = valid[v] & ~ready[v];

    // Saturating count of cycles where the sender waits on the receiver.
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_r <= 16'd0;
      end else if (clear) begin
        stall_r <= stall_s ? 16'd1 : 16'd0;
      end else if (stall_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end else begin
        stall_r <= stall_r;
      end
    end

    assign stall_count[v*16 +: 16] = stall_r;
`else
    assign stall_count[v*16 +: 16] = 16'd0;
`endif

    assign pkt_count[v*16 +: 16] = pkt_r;
    assign err[v*4 +: 4]         = err_r;
  end

  assign err_any = |err;

endmodule

// File: tb/tb_noc_link_checker.sv
// Directed self-checking bench for noc_link_checker (2 VCs, 32-bit flits).
// Stall-count expectations follow OPTIMSOC_NOC_CHECKER_STALLCNT_EN.
module tb_noc_link_checker;

`ifdef OPTIMSOC_NOC_CHECKER_STALLCNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [63:0] flit;
  logic [1:0]  last;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [31:0] pkt_count;
  logic [31:0] stall_count;
  logic [7:0]  err;
  logic        err_any;

  int vectors = 0;
  int miscompares = 0;

  noc_link_checker #(
    .FLIT_WIDTH (32),
    .CHANNELS   (2),
    .MAX_PKT_LEN(8),
    .NUM_DEST   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .flit       (flit),
    .last       (last),
    .valid      (valid),
    .ready      (ready),
    .pkt_count  (pkt_count),
    .stall_count(stall_count),
    .err        (err),
    .err_any    (err_any)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stall_exp(input int n);
    return STALL_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic r, input logic l, input logic [31:0] f);
    valid[0] = v; ready[0] = r; last[0] = l; flit[31:0] = f;
  endtask

  task automatic set1(input logic v, input logic r, input logic l, input logic [31:0] f);
    valid[1] = v; ready[1] = r; last[1] = l; flit[63:32] = f;
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; flit = 64'd0; last = 2'd0; valid = 2'd0; ready = 2'd0;
    tick(); tick();
    chk("reset_pkt",   pkt_count, 32'd0);
    chk("reset_stall", stall_count, 32'd0);
    chk("reset_err",   32'(err), 32'd0);
    chk("reset_any",   32'(err_any), 32'd0);
    rst = 1'b0;
    tick();

    // Single-flit packet on VC0, dest 2.
    set0(1'b1, 1'b1, 1'b1, 32'h1000_0000);
    tick();
    chk("single_pkt0", 32'(pkt_count[15:0]), 32'd1);
    chk("single_err",  32'(err), 32'd0);
    set0(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // 3-flit packet, second flit stalled two cycles and held stable.
    set0(1'b1, 1'b1, 1'b0, 32'h0000_0001);
    tick();
    set0(1'b1, 1'b0, 1'b0, 32'hAAAA_0002);
    tick();
    tick();
    set0(1'b1, 1'b1, 1'b0, 32'hAAAA_0002);
    tick();
    chk("stall_mid_pkt0", 32'(pkt_count[15:0]), 32'd1);
    set0(1'b1, 1'b1, 1'b1, 32'hBBBB_0003);
    tick();
    chk("stall_pkt0",   32'(pkt_count[15:0]), 32'd2);
    chk("stall_cnt0",   32'(stall_count[15:0]), stall_exp(2));
    chk("stall_err",    32'(err), 32'd0);
    set0(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // Valid drop on VC0, sticky until clear.
    set0(1'b1, 1'b0, 1'b0, 32'h0000_0005);
    tick();
    set0(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("drop_err0",  32'(err[3:0]), 32'h1);
    chk("drop_err1",  32'(err[7:4]), 32'h0);
    chk("drop_any",   32'(err_any), 32'd1);
    chk("drop_stall", 32'(stall_count[15:0]), stall_exp(3));
    tick();
    chk("drop_sticky", 32'(err[3:0]), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_err",   32'(err), 32'd0);
    chk("clear_any",   32'(err_any), 32'd0);
    chk("clear_pkt",   pkt_count, 32'd0);
    chk("clear_stall", stall_count, 32'd0);

    // Data change on VC1 while stalled, then accepted as a single flit.
    set1(1'b1, 1'b0, 1'b1, 32'h0000_0001);
    tick();
    set1(1'b1, 1'b0, 1'b1, 32'h0000_0002);
    tick();
    chk("chg_err1", 32'(err[7:4]), 32'h2);
    chk("chg_err0", 32'(err[3:0]), 32'h0);
    set1(1'b1, 1'b1, 1'b1, 32'h0000_0002);
    tick();
    chk("chg_pkt1",   32'(pkt_count[31:16]), 32'd1);
    chk("chg_stall1", 32'(stall_count[31:16]), stall_exp(2));
    chk("chg_err1_hold", 32'(err[7:4]), 32'h2);
    set1(1'b0, 1'b0, 1'b0, 32'd0);
    // Clear in the same cycle as a VC0 packet completion: counter loads 1.
    set0(1'b1, 1'b1, 1'b1, 32'h0000_0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrhs_pkt0",  32'(pkt_count[15:0]), 32'd1);
    chk("clrhs_pkt1",  32'(pkt_count[31:16]), 32'd0);
    chk("clrhs_err",   32'(err), 32'd0);
    chk("clrhs_stall", stall_count, 32'd0);

    // Bad destination header (dest 31) as a single flit.
    set0(1'b1, 1'b1, 1'b1, 32'hF800_0000);
    tick();
    chk("dest_err0", 32'(err[3:0]), 32'h8);
    chk("dest_pkt0", 32'(pkt_count[15:0]), 32'd2);
    chk("dest_any",  32'(err_any), 32'd1);

    // 9-flit packet: length error only once the 9th flit is accepted.
    for (int i = 1; i <= 8; i++) begin
      set0(1'b1, 1'b1, 1'b0, 32'(i));
      tick();
    end
    chk("len8_err0", 32'(err[3:0]), 32'h8);
    chk("len8_pkt0", 32'(pkt_count[15:0]), 32'd2);
    set0(1'b1, 1'b1, 1'b1, 32'h0000_0009);
    tick();
    chk("len9_err0", 32'(err[3:0]), 32'hC);
    chk("len9_pkt0", 32'(pkt_count[15:0]), 32'd3);
    set0(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Both VCs complete 2-flit packets in the same cycle.
    set0(1'b1, 1'b1, 1'b0, 32'd0);
    set1(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    set0(1'b1, 1'b1, 1'b1, 32'd1);
    set1(1'b1, 1'b1, 1'b1, 32'd1);
    tick();
    chk("both_pkt0", 32'(pkt_count[15:0]), 32'd1);
    chk("both_pkt1", 32'(pkt_count[31:16]), 32'd1);
    chk("both_err",  32'(err), 32'd0);

    // Reset while VC1 is mid-packet.
    set0(1'b0, 1'b0, 1'b0, 32'd0);
    set1(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    set1(1'b1, 1'b1, 1'b0, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pkt",   pkt_count, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_any",   32'(err_any), 32'd0);
    // A fresh header after reset is checked for its destination.
    set1(1'b1, 1'b1, 1'b1, 32'hF800_0000);
    tick();
    chk("fresh_pkt1", 32'(pkt_count[31:16]), 32'd1);
    chk("fresh_err1", 32'(err[7:4]), 32'h8);
    chk("fresh_pkt0", 32'(pkt_count[15:0]), 32'd0);
    set1(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
